// File: rtl/parser_pkg.sv
// parser_pkg: types and constants shared by the parser configuration logic.
//   conf_state_t    - configuration master FSM encoding
//   CONF_REG_*      - rule region codes carried in cmd addr[10:8]
//   region_legal()  - true for region codes that map onto a real rule table
package parser_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    READ    = 3'd2,
    WAIT_RD = 3'd3,
    DONE    = 3'd4
  } conf_state_t;

  localparam logic [2:0] CONF_REG_RULE        = 3'd0;
  localparam logic [2:0] CONF_REG_TYPE_DATA   = 3'd1;
  localparam logic [2:0] CONF_REG_TYPE_OFFSET = 3'd2;
  localparam logic [2:0] CONF_REG_KEY_OFFSET  = 3'd3;
  localparam logic [2:0] CONF_REG_HEAD_SHIFT  = 3'd4;
  localparam logic [2:0] CONF_REG_META_SHIFT  = 3'd5;
  localparam logic [2:0] CONF_REG_MAX         = CONF_REG_META_SHIFT;

  function automatic logic region_legal(input logic [2:0] region);
    return (region <= CONF_REG_MAX);
  endfunction

endpackage

// File: rtl/parser_conf_master.sv
// parser_conf_master: takes a stream of rule-write commands and replays them
// onto the Parser_Top rule port, one at a time, flagging bad regions and
// (optionally) verifying each write by reading it back.
//
// Optional feature macro: PARSER_CONF_READBACK_EN
//   defined   - every legal write is followed by a read of the same address;
//               mismatching data or a missing reply (RD_TIMEOUT cycles) is an error
//   undefined - write only; o_rule_rden is tied low, no timeout counter
//
// Ports
//   i_clk, i_rst_n                     clock, async active-low reset
//   i_cmd_valid/o_cmd_ready            command handshake (ready only in IDLE)
//   i_cmd_addr, i_cmd_wdata, i_cmd_last  command payload, end-of-batch flag
//   o_rule_wren, o_rule_rden           single-cycle rule write / read strobes
//   o_rule_addr, o_rule_wdata          latched command address / data
//   i_rule_rdata_valid, i_rule_rdata   read return (used only in WAIT_RD)
//   i_err_clr                          clears o_err / o_err_cnt
//   o_busy, o_done, o_err, o_err_cnt   status; o_err_cnt saturates
//
// state   | meaning
// IDLE    | ready for a command; decode region on acceptance
// WRITE   | o_rule_wren pulse with latched addr/data
// READ    | o_rule_rden pulse, same address (readback build only)
// WAIT_RD | waiting for read data or timeout (readback build only)
// DONE    | one-cycle o_done at the end of a batch
module parser_conf_master
  import parser_pkg::*;
#(
  parameter int RD_TIMEOUT = 16,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [31:0]          i_cmd_addr,
  input  logic [31:0]          i_cmd_wdata,
  input  logic                 i_cmd_last,
  output logic                 o_rule_wren,
  output logic                 o_rule_rden,
  output logic [31:0]          o_rule_addr,
  output logic [31:0]          o_rule_wdata,
  input  logic                 i_rule_rdata_valid,
  input  logic [31:0]          i_rule_rdata,
  input  logic                 i_err_clr,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  conf_state_t          state_q, state_d;
  logic [31:0]          addr_q, wdata_q;
  logic                 last_q;
  logic                 err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic                 cmd_acc;
  logic                 cmd_legal;
  logic                 err_event;

  assign cmd_acc   = i_cmd_valid && (state_q == IDLE);
  assign cmd_legal = region_legal(i_cmd_addr[10:8]);

`ifdef PARSER_CONF_READBACK_EN
  localparam int TMR_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  logic [TMR_W-1:0] tmr_q;

  // Loaded in READ so WAIT_RD lasts at most RD_TIMEOUT cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmr_q <= '0;
    end else if (state_q == READ) begin
      tmr_q <= TMR_W'(RD_TIMEOUT - 1);
    end else if ((state_q == WAIT_RD) && (tmr_q != '0)) begin
      tmr_q <= tmr_q - TMR_W'(1);
    end
  end
`else
  logic unused_rd;
  assign unused_rd = ^{i_rule_rdata_valid, i_rule_rdata, (RD_TIMEOUT > 0)};
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    err_event = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_acc) begin
          if (cmd_legal) begin
            state_d = WRITE;
          end else begin
            err_event = 1'b1;
            state_d   = i_cmd_last ? DONE : IDLE;
          end
        end
      end
      WRITE: begin
`ifdef PARSER_CONF_READBACK_EN
        state_d = READ;
`else
        state_d = last_q ? DONE : IDLE;
`endif
      end
`ifdef PARSER_CONF_READBACK_EN
      READ: begin
        state_d = WAIT_RD;
      end
      WAIT_RD: begin
        if (i_rule_rdata_valid) begin
          err_event = (i_rule_rdata != wdata_q);
          state_d   = last_q ? DONE : IDLE;
        end else if (tmr_q == '0) begin
          err_event = 1'b1;
          state_d   = last_q ? DONE : IDLE;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Payload is captured only on acceptance, so it stays put until the
  // command has fully retired.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
    end else if (cmd_acc) begin
      addr_q  <= i_cmd_addr;
      wdata_q <= i_cmd_wdata;
      last_q  <= i_cmd_last;
    end
  end

  // A fresh error beats a simultaneous clear: the count restarts at one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else if (err_event) begin
      err_q <= 1'b1;
      if (i_err_clr) begin
        err_cnt_q <= ERR_CNT_W'(1);
      end else if (err_cnt_q != '1) begin
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
    end else if (i_err_clr) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end
  end

  assign o_cmd_ready  = (state_q == IDLE);
  assign o_busy       = (state_q != IDLE);
  assign o_done       = (state_q == DONE);
  assign o_rule_wren  = (state_q == WRITE);
`ifdef PARSER_CONF_READBACK_EN
  assign o_rule_rden  = (state_q == READ);
`else
  assign o_rule_rden  = 1'b0;
`endif
  assign o_rule_addr  = addr_q;
  assign o_rule_wdata = wdata_q;
  assign o_err        = err_q;
  assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_parser_conf_master.sv
module tb_parser_conf_master;

  localparam int RD_TIMEOUT = 16;
  localparam int ERR_CNT_W  = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic [31:0]          cmd_addr = '0;
  logic [31:0]          cmd_wdata = '0;
  logic                 cmd_last = 1'b0;
  logic                 rule_wren, rule_rden;
  logic [31:0]          rule_addr, rule_wdata;
  logic                 rdata_valid = 1'b0;
  logic [31:0]          rdata = '0;
  logic                 err_clr = 1'b0;
  logic                 busy, done, err;
  logic [ERR_CNT_W-1:0] err_cnt;

  parser_conf_master #(.RD_TIMEOUT(RD_TIMEOUT), .ERR_CNT_W(ERR_CNT_W)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_cmd_valid        (cmd_valid),
    .o_cmd_ready        (cmd_ready),
    .i_cmd_addr         (cmd_addr),
    .i_cmd_wdata        (cmd_wdata),
    .i_cmd_last         (cmd_last),
    .o_rule_wren        (rule_wren),
    .o_rule_rden        (rule_rden),
    .o_rule_addr        (rule_addr),
    .o_rule_wdata       (rule_wdata),
    .i_rule_rdata_valid (rdata_valid),
    .i_rule_rdata       (rdata),
    .i_err_clr          (err_clr),
    .o_busy             (busy),
    .o_done             (done),
    .o_err              (err),
    .o_err_cnt          (err_cnt)
  );

  always #5 clk = ~clk;

  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   exp_cnt = 0;
  logic exp_err = 1'b0;
  int   strobe_clash = 0;

  always @(negedge clk) begin
    if (rule_wren && rule_rden) strobe_clash++;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        last;
    logic        legal;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic note_err();
    exp_err = 1'b1;
    if (exp_cnt < 255) exp_cnt++;
  endtask

  // Presents one command from IDLE and follows it until the FSM is back in IDLE.
  task automatic do_cmd(input vec_t v, input string tag);
    cmd_valid = 1'b1;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_last  = v.last;
    chk({tag, " ready"}, 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    if (v.legal) begin
      chk({tag, " wren"}, 32'(rule_wren), 32'd1);
      chk({tag, " rden_in_write"}, 32'(rule_rden), 32'd0);
      chk({tag, " addr"}, rule_addr, v.addr);
      chk({tag, " wdata"}, rule_wdata, v.wdata);
      chk({tag, " busy"}, 32'(busy), 32'd1);
      tick();
      chk({tag, " wren_one_cycle"}, 32'(rule_wren), 32'd0);
`ifdef PARSER_CONF_READBACK_EN
      chk({tag, " rden"}, 32'(rule_rden), 32'd1);
      chk({tag, " rd_addr"}, rule_addr, v.addr);
      tick();
      rdata_valid = 1'b1;
      rdata       = v.wdata;
      tick();
      rdata_valid = 1'b0;
`endif
    end else begin
      note_err();
      chk({tag, " no_wren"}, 32'(rule_wren), 32'd0);
    end
    chk({tag, " err"}, 32'(err), 32'(exp_err));
    chk({tag, " err_cnt"}, 32'(err_cnt), 32'(exp_cnt));
    if (v.last) begin
      chk({tag, " done"}, 32'(done), 32'd1);
      tick();
    end
    chk({tag, " done_clear"}, 32'(done), 32'd0);
    chk({tag, " idle_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    vec_t lv;
    int   lat;

    vecs[0] = '{addr: 32'h0000_0300, wdata: 32'h0001_000C, last: 1'b1, legal: 1'b1};
    vecs[1] = '{addr: 32'h0000_0600, wdata: 32'h0000_DEAD, last: 1'b0, legal: 1'b0};
    vecs[2] = '{addr: 32'h0000_0000, wdata: 32'h1111_1111, last: 1'b0, legal: 1'b1};
    vecs[3] = '{addr: 32'h0000_05FC, wdata: 32'hA5A5_A5A5, last: 1'b1, legal: 1'b1};
    vecs[4] = '{addr: 32'h0000_0700, wdata: 32'h0000_0001, last: 1'b1, legal: 1'b0};
    vecs[5] = '{addr: 32'h0000_0100, wdata: 32'h0000_0000, last: 1'b0, legal: 1'b1};
    vecs[6] = '{addr: 32'hFFFF_FA00, wdata: 32'hCAFE_F00D, last: 1'b0, legal: 1'b1};
    vecs[7] = '{addr: 32'h0000_0E00, wdata: 32'h0000_0042, last: 1'b0, legal: 1'b0};
    vecs[8] = '{addr: 32'h0000_0800, wdata: 32'h8000_0001, last: 1'b1, legal: 1'b1};

    // Reset state
    tick();
    tick();
    chk("rst wren", 32'(rule_wren), 32'd0);
    chk("rst rden", 32'(rule_rden), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst err_cnt", 32'(err_cnt), 32'd0);
    chk("rst addr", rule_addr, 32'd0);
    chk("rst wdata", rule_wdata, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      do_cmd(vecs[i], $sformatf("vec%0d", i));
    end

    // Read return outside WAIT_RD is ignored
    rdata_valid = 1'b1;
    rdata       = 32'h0BAD_0BAD;
    tick();
    tick();
    tick();
    rdata_valid = 1'b0;
    chk("stray_valid err_cnt", 32'(err_cnt), 32'(exp_cnt));
    chk("stray_valid busy", 32'(busy), 32'd0);

    // Plain clear
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_err = 1'b0;
    exp_cnt = 0;
    chk("clr err", 32'(err), 32'd0);
    chk("clr err_cnt", 32'(err_cnt), 32'd0);

    // Saturation: 300 back-to-back illegal commands
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_0600;
    cmd_wdata = 32'h0;
    cmd_last  = 1'b0;
    for (int n = 0; n < 300; n++) begin
      tick();
      note_err();
    end
    chk("sat err_cnt", 32'(err_cnt), 32'd255);
    chk("sat model", 32'(err_cnt), 32'(exp_cnt));
    chk("sat no_wren", 32'(rule_wren), 32'd0);

    // Clear together with a new error: the error wins
    err_clr = 1'b1;
    tick();
    err_clr   = 1'b0;
    cmd_valid = 1'b0;
    exp_cnt   = 1;
    exp_err   = 1'b1;
    chk("clr_vs_err err", 32'(err), 32'd1);
    chk("clr_vs_err err_cnt", 32'(err_cnt), 32'd1);

    // Reset mid-operation
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_0400;
    cmd_wdata = 32'h0000_0077;
    cmd_last  = 1'b1;
    tick();
    cmd_valid = 1'b0;
`ifdef PARSER_CONF_READBACK_EN
    tick();
    tick();
    chk("midrst in_wait busy", 32'(busy), 32'd1);
`else
    chk("midrst in_write wren", 32'(rule_wren), 32'd1);
`endif
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    exp_err = 1'b0;
    chk("midrst wren", 32'(rule_wren), 32'd0);
    chk("midrst rden", 32'(rule_rden), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst err", 32'(err), 32'd0);
    chk("midrst err_cnt", 32'(err_cnt), 32'd0);
    chk("midrst addr", rule_addr, 32'd0);
    chk("midrst wdata", rule_wdata, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    lv = '{addr: 32'h0000_0200, wdata: 32'h0000_1234, last: 1'b1, legal: 1'b1};
    do_cmd(lv, "post_rst");
    rdata_valid = 1'b1;
    rdata       = 32'hFFFF_0000;
    tick();
    rdata_valid = 1'b0;
    chk("post_rst stray err", 32'(err), 32'd0);
    chk("post_rst stray wren", 32'(rule_wren), 32'd0);

`ifdef PARSER_CONF_READBACK_EN
    // Readback mismatch: data returned 3 cycles after rden
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_0400;
    cmd_wdata = 32'h0000_0007;
    cmd_last  = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("mism rden", 32'(rule_rden), 32'd1);
    tick();
    tick();
    tick();
    rdata_valid = 1'b1;
    rdata       = 32'h0000_0006;
    tick();
    rdata_valid = 1'b0;
    note_err();
    chk("mism err", 32'(err), 32'd1);
    chk("mism err_cnt", 32'(err_cnt), 32'(exp_cnt));
    chk("mism done", 32'(done), 32'd1);
    tick();

    // Readback timeout: no data ever returned
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_0300;
    cmd_wdata = 32'h0000_0055;
    cmd_last  = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("tmo rden", 32'(rule_rden), 32'd1);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (32'(err_cnt) != exp_cnt) begin
        lat = n;
        break;
      end
    end
    note_err();
    chk("tmo latency", 32'(lat), 32'd17);
    chk("tmo err_cnt", 32'(err_cnt), 32'(exp_cnt));
    chk("tmo left_wait", 32'(cmd_ready), 32'd1);
`endif

    chk("wren_rden_exclusive", 32'(strobe_clash), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
